// File: rtl/egg_timer_ctrl_pkg.sv
// Shared definitions for the egg-timer sequencing controller:
// state encoding, seconds wrap value and button index map.
package egg_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_SET,
        S_RUN,
        S_PAUSE,
        S_ALARM
    } state_e;

    localparam int SEC_WRAP = 59;

    localparam int NUM_BTN   = 4;
    localparam int BTN_START = 0;
    localparam int BTN_CLEAR = 1;
    localparam int BTN_MINUP = 2;
    localparam int BTN_SECUP = 3;

endpackage

// File: rtl/egg_timer_ctrl_if.sv
// Front-end / counter bundle seen by the egg-timer controller.
// master = tick/button/counter side, slave = controller.
interface egg_timer_ctrl_if #(
    parameter int SEC_W = 6,
    parameter int MIN_W = 7
);
    logic             tick;
    logic             btnStart;
    logic             btnClear;
    logic             btnMinUp;
    logic             btnSecUp;
    logic [SEC_W-1:0] secQ;
    logic [MIN_W-1:0] minQ;
    logic             secLoad;
    logic             minLoad;
    logic [SEC_W-1:0] secLoadVal;
    logic [MIN_W-1:0] minLoadVal;
    logic             secStep;
    logic             minStep;
    logic             running;
    logic             alarm;

    modport master (
        output tick, btnStart, btnClear, btnMinUp, btnSecUp, secQ, minQ,
        input  secLoad, minLoad, secLoadVal, minLoadVal, secStep, minStep,
               running, alarm
    );

    modport slave (
        input  tick, btnStart, btnClear, btnMinUp, btnSecUp, secQ, minQ,
        output secLoad, minLoad, secLoadVal, minLoadVal, secStep, minStep,
               running, alarm
    );
endinterface

// File: rtl/egg_timer_ctrl_btn_pulse.sv
// Button conditioner: 2-FF synchronizer followed by a registered
// rising-edge detector, one pulse per press.
module btn_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic [1:0] r_sync;
    logic       r_prev;
    logic       r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_prev  <= r_sync[1];
            r_pulse <= r_sync[1] & ~r_prev;
        end
    end

    assign pulse = r_pulse;
endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg-timer sequencing controller: preset storage, counter load/step
// strobes and alarm. Optional alarm auto-clear via EGG_ALARM_TIMEOUT_EN.
module egg_timer_ctrl
    import egg_timer_ctrl_pkg::*;
#(
    parameter int SEC_W       = 6,
    parameter int MIN_W       = 7,
    parameter int MIN_MAX     = 99,
    parameter int DEFAULT_MIN = 3,
    parameter int ALARM_SECS  = 30
) (
    input  logic              clk,
    input  logic              reset,
    egg_timer_ctrl_if.slave   bus
);
    logic [NUM_BTN-1:0] w_btnRaw;
    logic [NUM_BTN-1:0] w_btnPulse;

    assign w_btnRaw[BTN_START] = bus.btnStart;
    assign w_btnRaw[BTN_CLEAR] = bus.btnClear;
    assign w_btnRaw[BTN_MINUP] = bus.btnMinUp;
    assign w_btnRaw[BTN_SECUP] = bus.btnSecUp;

    generate
        for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_pulse u_btn (
                .clk   (clk),
                .rst_n (reset),
                .btn   (w_btnRaw[g]),
                .pulse (w_btnPulse[g])
            );
        end
    endgenerate

    logic w_clr, w_start, w_minUp, w_secUp;
    assign w_clr   = w_btnPulse[BTN_CLEAR];
    assign w_start = w_btnPulse[BTN_START];
    assign w_minUp = w_btnPulse[BTN_MINUP];
    assign w_secUp = w_btnPulse[BTN_SECUP];

    state_e           r_state, w_stateNxt;
    logic [MIN_W-1:0] r_presetMin, w_presetMinNxt;
    logic [SEC_W-1:0] r_presetSec, w_presetSecNxt;
    logic             r_load, w_load;
    logic             r_secStep, w_secStep;
    logic             r_minStep, w_minStep;

    logic w_presetZero, w_minZero, w_secZero, w_secOne;
    assign w_presetZero = (r_presetMin == '0) && (r_presetSec == '0);
    assign w_minZero    = (bus.minQ == '0);
    assign w_secZero    = (bus.secQ == '0);
    assign w_secOne     = (bus.secQ == SEC_W'(1));

`ifdef EGG_ALARM_TIMEOUT_EN
    localparam int ACNT_W = $clog2(ALARM_SECS + 1);
    logic [ACNT_W-1:0] r_alarmCnt;
    logic              w_alarmCntInc;
    logic              w_alarmExpire;
    assign w_alarmExpire = (r_alarmCnt == ACNT_W'(ALARM_SECS - 1));
`endif

    always_comb begin
        w_stateNxt     = r_state;
        w_presetMinNxt = r_presetMin;
        w_presetSecNxt = r_presetSec;
        w_load         = 1'b0;
        w_secStep      = 1'b0;
        w_minStep      = 1'b0;
`ifdef EGG_ALARM_TIMEOUT_EN
        w_alarmCntInc  = 1'b0;
`endif
        case (r_state)
            S_INIT: begin
                w_stateNxt = S_SET;
                w_load     = 1'b1;
            end
            S_SET: begin
                // Each event class masks all lower-priority ones in the cycle.
                if (w_clr) begin
                    w_load = 1'b1;
                end else if (w_start) begin
                    if (!w_presetZero) w_stateNxt = S_RUN;
                end else if (w_minUp || w_secUp) begin
                    if (w_minUp)
                        w_presetMinNxt = (r_presetMin == MIN_W'(MIN_MAX)) ? '0
                                                                           : r_presetMin + 1'b1;
                    if (w_secUp)
                        w_presetSecNxt = (r_presetSec == SEC_W'(SEC_WRAP)) ? '0
                                                                            : r_presetSec + 1'b1;
                    w_load = 1'b1;
                end
            end
            S_RUN: begin
                if (w_clr) begin
                    w_stateNxt = S_SET;
                    w_load     = 1'b1;
                end else if (w_start) begin
                    w_stateNxt = S_PAUSE;
                end else if (bus.tick) begin
                    if (w_minZero && w_secOne) begin
                        w_secStep  = 1'b1;
                        w_stateNxt = S_ALARM;
                    end else if (w_minZero && w_secZero) begin
                        w_stateNxt = S_ALARM;
                    end else begin
                        w_secStep = 1'b1;
                        w_minStep = w_secZero;
                    end
                end
            end
            S_PAUSE: begin
                if (w_clr) begin
                    w_stateNxt = S_SET;
                    w_load     = 1'b1;
                end else if (w_start) begin
                    w_stateNxt = S_RUN;
                end
            end
            S_ALARM: begin
                if (w_clr || w_start) begin
                    w_stateNxt = S_SET;
                    w_load     = 1'b1;
                end
`ifdef EGG_ALARM_TIMEOUT_EN
                else if (bus.tick) begin
                    if (w_alarmExpire) begin
                        w_stateNxt = S_SET;
                        w_load     = 1'b1;
                    end else begin
                        w_alarmCntInc = 1'b1;
                    end
                end
`endif
            end
            default: w_stateNxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_INIT;
            r_presetMin <= MIN_W'(DEFAULT_MIN);
            r_presetSec <= '0;
            r_load      <= 1'b0;
            r_secStep   <= 1'b0;
            r_minStep   <= 1'b0;
        end else begin
            r_state     <= w_stateNxt;
            r_presetMin <= w_presetMinNxt;
            r_presetSec <= w_presetSecNxt;
            r_load      <= w_load;
            r_secStep   <= w_secStep;
            r_minStep   <= w_minStep;
        end
    end

`ifdef EGG_ALARM_TIMEOUT_EN
    // Held at zero outside ALARM, so every entry starts a fresh count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_alarmCnt <= '0;
        else if (r_state != S_ALARM)
            r_alarmCnt <= '0;
        else if (w_alarmCntInc)
            r_alarmCnt <= r_alarmCnt + 1'b1;
    end
`endif

    assign bus.secLoad    = r_load;
    assign bus.minLoad    = r_load;
    assign bus.secLoadVal = r_presetSec;
    assign bus.minLoadVal = r_presetMin;
    assign bus.secStep    = r_secStep;
    assign bus.minStep    = r_minStep;
    assign bus.running    = (r_state == S_RUN);
    assign bus.alarm      = (r_state == S_ALARM);
endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: mode/remaining-time reference model feeds an
// expected-strobe queue; a negedge monitor pops and compares every strobe.
module tb_egg_timer_ctrl;
    localparam int SEC_W      = 6;
    localparam int MIN_W      = 7;
    localparam int MIN_MAX    = 99;
    localparam int DEF_MIN    = 3;
    localparam int ALARM_SECS = 30;

    localparam int B_START = 0, B_CLEAR = 1, B_MINUP = 2, B_SECUP = 3;
    localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    egg_timer_ctrl_if #(.SEC_W(SEC_W), .MIN_W(MIN_W)) bus ();

    egg_timer_ctrl #(
        .SEC_W(SEC_W), .MIN_W(MIN_W), .MIN_MAX(MIN_MAX),
        .DEFAULT_MIN(DEF_MIN), .ALARM_SECS(ALARM_SECS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Display counters driven by the controller strobes
    logic [SEC_W-1:0] c_sec = '0;
    logic [MIN_W-1:0] c_min = '0;
    always @(posedge clk) begin
        if (bus.secLoad)      c_sec <= bus.secLoadVal;
        else if (bus.secStep) c_sec <= (c_sec == 0) ? SEC_W'(59) : c_sec - 1'b1;
        if (bus.minLoad)      c_min <= bus.minLoadVal;
        else if (bus.minStep) c_min <= c_min - 1'b1;
    end
    assign bus.secQ = c_sec;
    assign bus.minQ = c_min;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic             ld;
        logic             ss;
        logic             ms;
        logic [MIN_W-1:0] mv;
        logic [SEC_W-1:0] sv;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    // Reference model: user-visible mode, preset, and seconds left on display
    int m_mode, m_pmin, m_psec, m_rem, m_acnt;

    function automatic void push_ev(input logic ld, input logic ss, input logic ms);
        ev_t e;
        e.ld = ld; e.ss = ss; e.ms = ms;
        e.mv = m_pmin[MIN_W-1:0];
        e.sv = m_psec[SEC_W-1:0];
        exp_q.push_back(e);
    endfunction

    function automatic void reload();
        m_mode = M_SET;
        push_ev(1'b1, 1'b0, 1'b0);
        m_rem = m_pmin * 60 + m_psec;
    endfunction

    function automatic void mdl_btn(input int b);
        case (b)
            B_CLEAR: reload();
            B_START: begin
                if (m_mode == M_SET && (m_pmin * 60 + m_psec) != 0) m_mode = M_RUN;
                else if (m_mode == M_RUN)   m_mode = M_PAUSE;
                else if (m_mode == M_PAUSE) m_mode = M_RUN;
                else if (m_mode == M_ALARM) reload();
            end
            B_MINUP: if (m_mode == M_SET) begin
                m_pmin = (m_pmin + 1) % (MIN_MAX + 1);
                reload();
            end
            default: if (m_mode == M_SET) begin
                m_psec = (m_psec + 1) % 60;
                reload();
            end
        endcase
    endfunction

    function automatic void mdl_tick();
        if (m_mode == M_RUN) begin
            if (m_rem <= 1) begin
                if (m_rem == 1) push_ev(1'b0, 1'b1, 1'b0);
                m_rem  = 0;
                m_mode = M_ALARM;
                m_acnt = 0;
            end else begin
                push_ev(1'b0, 1'b1, (m_rem % 60) == 0);
                m_rem--;
            end
        end else if (m_mode == M_ALARM) begin
`ifdef EGG_ALARM_TIMEOUT_EN
            m_acnt++;
            if (m_acnt == ALARM_SECS) reload();
`endif
        end
    endfunction

    always @(negedge clk) begin
        if (reset && (bus.secLoad || bus.minLoad || bus.secStep || bus.minStep)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_strobe: got ld=%0b ss=%0b ms=%0b expected none",
                         bus.secLoad, bus.secStep, bus.minStep);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_loads", {bus.secLoad, bus.minLoad}, {mon_e.ld, mon_e.ld});
                check("strobe_steps", {bus.secStep, bus.minStep}, {mon_e.ss, mon_e.ms});
                check("load_val_min", bus.minLoadVal, mon_e.mv);
                check("load_val_sec", bus.secLoadVal, mon_e.sv);
            end
        end
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_START: bus.btnStart = v;
            B_CLEAR: bus.btnClear = v;
            B_MINUP: bus.btnMinUp = v;
            default: bus.btnSecUp = v;
        endcase
    endtask

    // Button pulse is seen by the controller on the 4th edge after the press.
    task automatic press(input int b, input bit with_tick = 1'b0);
        mdl_btn(b);
        set_btn(b, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        if (with_tick) bus.tick = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 set_btn(b, 1'b0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        mdl_tick();
        bus.tick = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        repeat ($urandom_range(2, 4)) @(posedge clk);
        #1;
    endtask

    task automatic set_preset(input int mn, input int sc);
        while (m_pmin != mn) press(B_MINUP);
        while (m_psec != sc) press(B_SECUP);
    endtask

    task automatic check_display(input string name);
        check(name, 32'(c_min) * 60 + 32'(c_sec), m_rem);
    endtask

    task automatic check_mode(input string name);
        check({name, "_running"}, bus.running, m_mode == M_RUN);
        check({name, "_alarm"},   bus.alarm,   m_mode == M_ALARM);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick = 1'b0; bus.btnStart = 1'b0; bus.btnClear = 1'b0;
        bus.btnMinUp = 1'b0; bus.btnSecUp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_loads", {bus.secLoad, bus.minLoad}, 0);
        check("rst_steps", {bus.secStep, bus.minStep}, 0);
        check("rst_status", {bus.running, bus.alarm}, 0);
        check("rst_preset_min", bus.minLoadVal, DEF_MIN);
        check("rst_preset_sec", bus.secLoadVal, 0);

        m_pmin = DEF_MIN; m_psec = 0; m_acnt = 0;
        reload();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("init_load_seen", exp_q.size(), 0);
        check_mode("after_init");
        check_display("init_display");

        // Preset wrap
        repeat (100) press(B_MINUP);
        check("min_wrap", bus.minLoadVal, DEF_MIN);
        repeat (61) press(B_SECUP);
        check("sec_wrap", bus.secLoadVal, 1);

        // Minute borrow
        set_preset(1, 0);
        press(B_START);
        check_mode("borrow_start");
        do_tick();
        check("borrow_min", c_min, 0);
        check("borrow_sec", c_sec, 59);
        press(B_CLEAR);
        check_mode("borrow_clear");

        // Full run to alarm
        set_preset(0, 3);
        press(B_START);
        repeat (3) do_tick();
        check_mode("full_alarm");
        check("full_alarm_flag", bus.alarm, 1);
        do_tick();
        press(B_CLEAR);
        check("clear_disp_min", c_min, 0);
        check("clear_disp_sec", c_sec, 3);
        check_mode("full_clear");

        // Pause, tick/start collision, start at 00:00
        set_preset(0, 10);
        press(B_START);
        repeat (2) do_tick();
        press(B_START);
        check_mode("paused");
        repeat (3) do_tick();
        check_display("paused_display");
        press(B_START);
        check_mode("resumed");
        press(B_START, 1'b1);
        check_mode("collision_pause");
        do_tick();
        press(B_CLEAR);
        set_preset(0, 0);
        press(B_START);
        check_mode("start_zero");
        do_tick();
        press(B_MINUP);
        check("zero_stays_set", bus.minLoadVal, 1);

        // Alarm hold / timeout
        set_preset(0, 1);
        press(B_START);
        do_tick();
        check_mode("alarm_entry");
`ifdef EGG_ALARM_TIMEOUT_EN
        repeat (ALARM_SECS - 1) do_tick();
        check("alarm_before_timeout", bus.alarm, 1);
        do_tick();
        check("alarm_after_timeout", bus.alarm, 0);
`else
        repeat (100) do_tick();
        check("alarm_persists", bus.alarm, 1);
`endif
        check_mode("alarm_end");
        press(B_CLEAR);

        // Randomised sessions
        for (int it = 0; it < 8; it++) begin
            press(B_CLEAR);
            repeat ($urandom_range(0, 1)) press(B_MINUP);
            repeat ($urandom_range(0, 8)) press(B_SECUP);
            if (m_pmin == 0 && m_psec == 0) press(B_SECUP);
            press(B_START);
            for (int k = 0, n = $urandom_range(3, 12); k < n; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 7)      do_tick();
                else if (r == 7) press(B_START);
                else if (r == 8) press(B_START, 1'b1);
                else             check_display("rand_display");
            end
            check_mode("rand_mode");
            check_display("rand_end_display");
        end

        // Reset mid-operation
        press(B_CLEAR);
        if (m_pmin == 0 && m_psec == 0) press(B_SECUP);
        press(B_START);
        do_tick();
        reset = 1'b0;
        #2;
        check("midrst_strobes",
              {bus.secLoad, bus.minLoad, bus.secStep, bus.minStep}, 0);
        check("midrst_status", {bus.running, bus.alarm}, 0);
        m_pmin = DEF_MIN; m_psec = 0;
        reload();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_display("midrst_reload");
        check_mode("midrst_mode");

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/egg_timer_ctrl.md
# egg_timer_ctrl

Sequencing controller for the egg-timer minute/second down-counters. Holds the user-set preset, loads it into both counters, turns the 1 Hz tick into per-counter decrement strobes, and raises the alarm at 00:00. Sits between the button/tick front end and the two counter instances that drive the display.

## Interface
- `SEC_W`, default 6: seconds counter width.
- `MIN_W`, default 7: minutes counter width.
- `MIN_MAX`, default 99: largest settable minute value.
- `DEFAULT_MIN`, default 3: preset minutes after reset.
- `ALARM_SECS`, default 30: alarm auto-clear time in ticks. Used only with `EGG_ALARM_TIMEOUT_EN`.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `tick`, input, 1: 1 Hz enable, one `clk` cycle wide, synchronous to `clk`.
- `btnStart`, `btnClear`, `btnMinUp`, `btnSecUp`, input, 1 each: raw button levels, asynchronous.
- `secQ`, input, SEC_W: current seconds count.
- `minQ`, input, MIN_W: current minutes count.
- `secLoad`, `minLoad`, output, 1: one-cycle load strobes to the counters.
- `secLoadVal`, output, SEC_W: seconds load value. Always equals `presetSec`.
- `minLoadVal`, output, MIN_W: minutes load value. Always equals `presetMin`.
- `secStep`, `minStep`, output, 1: one-cycle decrement enables. The seconds counter wraps 0→59.
- `running`, output, 1: high in RUN.
- `alarm`, output, 1: high in ALARM.

## Operation
- **Button conditioning:** every button passes through a 2-FF synchronizer and a rising-edge detector. This yields one pulse per press.
- **States:** INIT, SET, RUN, PAUSE, ALARM.
- **INIT:** entered on reset. Pulses `secLoad` and `minLoad` for one cycle, then goes to SET unconditionally.
- **SET:**
  - `btnMinUp` increments `presetMin`, wrapping MIN_MAX→0.
  - `btnSecUp` increments `presetSec`, wrapping 59→0.
  - Each adjust also pulses both loads on the following cycle, so the display tracks the preset.
  - `btnStart` goes to RUN only if the preset is not 00:00. A start at 00:00 is ignored.
- **RUN:** on `tick`:
  - If `minQ==0` and `secQ==1`: pulse `secStep` and go to ALARM.
  - Else if `minQ==0` and `secQ==0` (guard case): go to ALARM with no step.
  - Else: pulse `secStep`. If `secQ==0`, also pulse `minStep` in the same cycle.
  - `btnStart` goes to PAUSE.
- **PAUSE:** ticks are ignored. `btnStart` goes to RUN.
- **ALARM:** `btnStart` or `btnClear` goes to SET and pulses both loads.
- **Clear:** `btnClear` in any state except INIT goes to SET and pulses both loads. The preset is retained.
- **Priority within one cycle:** `btnClear` > `btnStart` > `tick` > adjust buttons. Lower-priority events in that cycle are dropped, not queued. Example: `tick` together with `btnStart` in RUN means PAUSE is entered with no step.
- **Presets:** the preset registers change only in SET. Values above MIN_MAX cannot be reached.

## Timing
- **Reset values:**
  - State INIT.
  - `presetMin`=DEFAULT_MIN, `presetSec`=0.
  - All strobes 0.
  - `running`=0, `alarm`=0.
- **Registered outputs:** all outputs are registered.
  - A strobe appears the cycle after the qualifying `tick` or button pulse.
- **Button latency:** 3 `clk` cycles from a button level change to the edge pulse (2-FF synchronizer plus edge detect), plus 1 more cycle to the resulting output.
- **Loads and steps:** `secLoad`/`minLoad` are never asserted in the same cycle as `secStep`/`minStep`.
- **Status outputs:** `running` and `alarm` change in the same cycle as the state register.
- **Reset mid-operation:** all outputs return to their reset values asynchronously. INIT then reloads DEFAULT_MIN:00 into the counters.

## Configuration
- **`EGG_ALARM_TIMEOUT_EN` defined:**
  - An internal counter sized `$clog2(ALARM_SECS+1)` counts ticks in ALARM.
  - On the ALARM_SECS-th tick the controller goes to SET and pulses both loads.
  - The counter clears on entry to ALARM.
- **Undefined:** ALARM persists until `btnStart` or `btnClear`. No timeout logic is generated.

## Structure
- **Shared package:** state encoding enum and the seconds wrap constant (59).
- **Sub-module `btn_pulse`:** one instance per button, four in total. It contains the synchronizer and rising-edge detector (1-bit input `btn`, output `pulse`).

## Test plan
- **Reset default:** release reset → one `secLoad`+`minLoad` pulse with `minLoadVal`=3, `secLoadVal`=0. State is SET and `alarm`=0.
- **Preset wrap:** in SET, 100 `btnMinUp` presses give `presetMin`=99→0. 61 `btnSecUp` presses give `presetSec`=1.
- **Minute borrow:** preset 01:00, start, one tick → `secStep` and `minStep` in the same cycle. Counter model shows 00:59.
- **Full run:** preset 00:03, start, 3 ticks → three `secStep` pulses, then `alarm`=1 and `running`=0. `btnClear` → SET with both loads showing 00:03.
- **Pause and collision:** start then pause mid-run → ticks produce no steps. `tick` together with `btnStart` in RUN → PAUSE with no step. Start at preset 00:00 → state stays SET.
- **Alarm timeout (with `EGG_ALARM_TIMEOUT_EN`):** 30 ticks in ALARM → SET and loads pulsed. Without the macro, 100 ticks → `alarm` stays 1.
